// File: rtl/targ_uart_rx_fifo.sv
// rtl/targ_uart_rx_fifo.sv - 8x-oversampled UART receiver with runtime frame format, break detect and FWFT receive FIFO
module targ_uart_rx_fifo #(
    parameter int ACC_WIDTH  = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int FILT_CNT   = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rxd,
    input  logic [ACC_WIDTH-1:0]          baud8_inc,
    input  logic [1:0]                    data_bits,
    input  logic                          parity_en,
    input  logic                          parity_odd,
    input  logic                          two_stopbits,
    input  logic                          rd_en,
    output logic                          rd_valid,
    output logic [7:0]                    rd_data,
    output logic                          rd_parity_err,
    output logic                          rd_frame_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    input  logic                          overflow_clr,
    output logic                          break_det,
    output logic                          rx_idle,
    output logic                          rx_endofpacket
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [FILT_CNT-1:0] FILT_MAX = '1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK_WAIT} stateT;

    logic [ACC_WIDTH:0]    acc;
    logic                  tick;
    logic [1:0]            syncReg;
    logic [FILT_CNT-1:0]   filtCnt;
    logic                  lineLow;
    stateT                 state, stateNext;
    logic [2:0]            phase, bitIdx, lastIdx;
    logic [1:0]            cfgBits;
    logic                  cfgPar, cfgOdd, cfgTwo;
    logic [7:0]            dataReg;
    logic                  parityBit, frameErr;
    logic                  sampleNow, complete, isBreak, parityErr, frameErrNext;
    logic                  pushValid;
    logic [9:0]            pushWord;
    logic [4:0]            gap;

    assign tick = acc[ACC_WIDTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) acc <= '0;
        else       acc <= {1'b0, acc[ACC_WIDTH-1:0]} + {1'b0, baud8_inc};
    end

    // lineLow is the filtered, inverted line: 1 means the wire is low
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            syncReg <= 2'b00;
            filtCnt <= '0;
            lineLow <= 1'b0;
        end else if (tick) begin
            syncReg <= {syncReg[0], ~rxd};
            if (syncReg[1] && filtCnt != FILT_MAX)      filtCnt <= filtCnt + 1'b1;
            else if (!syncReg[1] && filtCnt != '0)      filtCnt <= filtCnt - 1'b1;
            if (filtCnt == FILT_MAX)  lineLow <= 1'b1;
            else if (filtCnt == '0)   lineLow <= 1'b0;
        end
    end

    assign lastIdx      = 3'd4 + {1'b0, cfgBits};
    assign sampleNow    = tick && (phase == 3'd7);
    assign frameErrNext = frameErr | lineLow;
    assign parityErr    = cfgPar && ((^dataReg ^ parityBit) != cfgOdd);
    // STOP1's sample lives in frameErr once we have moved on to STOP2
    assign isBreak      = (dataReg == 8'h00) && !(cfgPar && parityBit)
                          && ((state == STOP1) ? lineLow : frameErr);

    always_comb begin
        stateNext = state;
        complete  = 1'b0;
        if (tick) begin
            case (state)
                IDLE:       if (lineLow) stateNext = START;
                START:      if (phase == 3'd3) stateNext = lineLow ? DATA : IDLE;
                DATA:       if (phase == 3'd7 && bitIdx == lastIdx) stateNext = cfgPar ? PARITY : STOP1;
                PARITY:     if (phase == 3'd7) stateNext = STOP1;
                STOP1:      if (phase == 3'd7) begin
                                if (cfgTwo) stateNext = STOP2;
                                else        complete  = 1'b1;
                            end
                STOP2:      if (phase == 3'd7) complete = 1'b1;
                BREAK_WAIT: if (!lineLow) stateNext = IDLE;
                default:    stateNext = IDLE;
            endcase
        end
        if (complete) stateNext = isBreak ? BREAK_WAIT : IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            phase     <= 3'd0;
            bitIdx    <= 3'd0;
            cfgBits   <= 2'd0;
            cfgPar    <= 1'b0;
            cfgOdd    <= 1'b0;
            cfgTwo    <= 1'b0;
            dataReg   <= 8'h00;
            parityBit <= 1'b0;
            frameErr  <= 1'b0;
            pushValid <= 1'b0;
            pushWord  <= 10'h000;
            break_det <= 1'b0;
        end else begin
            pushValid <= 1'b0;
            break_det <= 1'b0;
            if (tick) begin
                state <= stateNext;
                phase <= (stateNext != state) ? 3'd0 : phase + 3'd1;
                if (state == IDLE && stateNext == START) begin
                    cfgBits   <= data_bits;
                    cfgPar    <= parity_en;
                    cfgOdd    <= parity_odd;
                    cfgTwo    <= two_stopbits;
                    dataReg   <= 8'h00;
                    bitIdx    <= 3'd0;
                    parityBit <= 1'b0;
                    frameErr  <= 1'b0;
                end
                if (sampleNow) begin
                    case (state)
                        DATA: begin
                            dataReg[bitIdx] <= ~lineLow;
                            bitIdx          <= bitIdx + 3'd1;
                        end
                        PARITY:  parityBit <= ~lineLow;
                        STOP1:   frameErr  <= lineLow;
                        STOP2:   frameErr  <= frameErrNext;
                        default: ;
                    endcase
                end
                if (complete) begin
                    if (isBreak) break_det <= 1'b1;
                    else begin
                        pushValid <= 1'b1;
                        pushWord  <= {frameErrNext, parityErr, dataReg};
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gap            <= 5'd0;
            rx_endofpacket <= 1'b0;
        end else begin
            rx_endofpacket <= tick && (gap == 5'd15);
            if (state != IDLE)         gap <= 5'd0;
            else if (tick && !gap[4])  gap <= gap + 5'd1;
        end
    end
    assign rx_idle = gap[4];

    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    logic [AW:0]   count;
    logic          full, doPop, doPush;
    logic [9:0]    head;

    assign full   = (count == FULL_CNT);
    assign doPop  = rd_en && (count != '0);
    assign doPush = pushValid && (!full || doPop);

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= pushWord;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (pushValid && full && !doPop) overflow <= 1'b1;
            else if (overflow_clr)           overflow <= 1'b0;
        end
    end

    assign head          = mem[rdPtr];
    assign rd_valid      = (count != '0);
    assign rd_data       = rd_valid ? head[7:0] : 8'h00;
    assign rd_parity_err = rd_valid & head[8];
    assign rd_frame_err  = rd_valid & head[9];
    assign fifo_count    = count;
endmodule
